riscv_wb_checker: RTL

Synthesisable, self-checking writeback monitor for the riscv_pipeline writeback port (wb_e/wb_a/wb_d).
- Holds an in-order queue of expected (rd, data) retirements.
- Compares each observed writeback against the queue head and keeps pass/fail counts.
- Flags mismatches, unexpected writebacks and retirement timeouts.
- Replaces hand-timed, cycle-counted checks in benches; also usable on FPGA next to the core.

---
 rtl/riscv_wb_chk_pkg.sv | 39 +++
 rtl/riscv_wb_chk_fifo.sv | 49 ++++
 rtl/riscv_wb_checker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_wb_chk_pkg.sv
// Shared types for the riscv_wb_checker writeback monitor.
// Optional build macro: RISCV_WB_CHK_HALT_EN adds a HALT state that freezes
// the checker after its first failed check.
package riscv_wb_chk_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_DATA  = 2'd1,
      ERR_ADDR  = 2'd2,
      ERR_UNEXP = 2'd3
   } err_code_e;

   // The ST_ prefix keeps these names clear of the TIMEOUT parameter in the checker.
`ifdef RISCV_WB_CHK_HALT_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_TIMEOUT = 2'd2,
      ST_HALT    = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_e;
`endif

   // Default-width expectation entry. The checker declares a local copy of
   // this layout sized by its own XLEN/REG_AW parameters.
   typedef struct packed {
      logic [REG_AW_DEF-1:0] a;
      logic [XLEN_DEF-1:0]   d;
   } wb_entry_t;

endpackage

// File: rtl/riscv_wb_chk_fifo.sv
// Circular expectation queue for riscv_wb_checker. Pointers carry one extra
// wrap bit so that full and empty are distinguishable when the indices match.
module riscv_wb_chk_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 37
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset discards every queued entry at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/riscv_wb_checker.sv
// Writeback monitor: compares each pipeline writeback against an in-order
// queue of expected (rd, data) retirements and reports results.
// Optional build macro: RISCV_WB_CHK_HALT_EN (freeze on first failure).
module riscv_wb_checker
   import riscv_wb_chk_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int REG_AW  = 5,
   parameter int DEPTH   = 16,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   exp_valid,
   output logic                   exp_ready,
   input  logic [REG_AW-1:0]      exp_a,
   input  logic [XLEN-1:0]        exp_d,
   input  logic                   wb_e,
   input  logic [REG_AW-1:0]      wb_a,
   input  logic [XLEN-1:0]        wb_d,
   output logic [CNT_W-1:0]       pass_cnt,
   output logic [CNT_W-1:0]       fail_cnt,
   output logic                   err_valid,
   output logic [1:0]             err_code,
   output logic [REG_AW-1:0]      err_exp_a,
   output logic [XLEN-1:0]        err_exp_d,
   output logic [REG_AW-1:0]      err_act_a,
   output logic [XLEN-1:0]        err_act_d,
   output logic                   done,
   output logic                   timed_out,
   output logic [$clog2(DEPTH):0] level
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [TW-1:0]    TIMER_END = TW'(TIMEOUT);

   typedef struct packed {
      logic [REG_AW-1:0] a;
      logic [XLEN-1:0]   d;
   } entry_t;

   state_e    state;
   state_e    state_next;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_next;
   err_code_e code;
   err_code_e err_code_q;
   entry_t    push_entry;
   entry_t    head;
   logic      push;
   logic      pop;
   logic      check;
   logic      fail;
   logic      pass_hit;
   logic      full;
   logic      empty;

   assign push_entry = '{a: exp_a, d: exp_d};
   assign push       = exp_valid && exp_ready;
   assign pop        = check && !empty;
   assign fail       = check && (code != ERR_NONE);
   assign pass_hit   = check && (code == ERR_NONE);

`ifdef RISCV_WB_CHK_HALT_EN
   assign exp_ready = !full && (state != ST_HALT);
`else
   assign exp_ready = !full;
`endif

   assign done      = (state == ST_RUN) && empty;
   assign timed_out = (state == ST_TIMEOUT);
   assign err_code  = err_code_q;

   riscv_wb_chk_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Compare against the queue head (address first), then work out the next state and timer.
   always_comb begin
      state_next = state;
      timer_next = timer;
      check      = 1'b0;
      code       = ERR_NONE;

      if ((state == ST_RUN) && wb_e && (wb_a != '0)) begin
         check = 1'b1;
         if (empty)                code = ERR_UNEXP;
         else if (wb_a != head.a)  code = ERR_ADDR;
         else if (wb_d != head.d)  code = ERR_DATA;
      end

      case (state)
         ST_IDLE: begin
            timer_next = '0;
            if (push) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (check || empty)          timer_next = '0;
            else if (timer != TIMER_END) timer_next = timer + TW'(1);
`ifdef RISCV_WB_CHK_HALT_EN
            if (fail)                           state_next = ST_HALT;
            else if (timer_next == TIMER_END)   state_next = ST_TIMEOUT;
`else
            if (timer_next == TIMER_END)        state_next = ST_TIMEOUT;
`endif
         end
         default: begin
            state_next = state;
         end
      endcase
   end

   // State, timer, saturating counters and the held failure report.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         timer      <= '0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         err_valid  <= 1'b0;
         err_code_q <= ERR_NONE;
         err_exp_a  <= '0;
         err_exp_d  <= '0;
         err_act_a  <= '0;
         err_act_d  <= '0;
      end else begin
         state     <= state_next;
         timer     <= timer_next;
         err_valid <= fail;
         if (pass_hit && (pass_cnt != CNT_MAX)) pass_cnt <= pass_cnt + CNT_W'(1);
         if (fail) begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
            err_code_q <= code;
            err_exp_a  <= empty ? '0 : head.a;
            err_exp_d  <= empty ? '0 : head.d;
            err_act_a  <= wb_a;
            err_act_d  <= wb_d;
         end
      end
   end

endmodule
